// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED channel scanner.
package led_scan_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    FLASH = 1'b1
  } scan_state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Terminal-count counter: counts 0..CYCLES-1 while enabled, tc is high on the last count.
module led_dwell_timer
  import led_scan_pkg::*;
#(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = clog2_min1(CYCLES);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == CW'(CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_channel_scanner.sv
// Selects one of CHANNELS words for the LEDs; advances on a button pulse or after a dwell time.
// Optional index-flash phase after each advance is built when LED_SCAN_INDEX_FLASH_EN is defined.
module led_channel_scanner
  import led_scan_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CHANNELS     = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int FLASH_CYCLES = 12_500_000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHANNELS*WIDTH-1:0]         ch_data,
  input  logic                              next_pulse,
  input  logic                              auto_en,
  output logic [clog2_min1(CHANNELS)-1:0]   sel,
  output logic [WIDTH-1:0]                  leds
);

  localparam int SELW = clog2_min1(CHANNELS);

  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [WIDTH-1:0] ch_word [CHANNELS];
  scan_state_e      state;
  logic             in_show;
  logic             dwell_tc;
  logic             advance;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign ch_word[gi] = ch_data[gi*WIDTH +: WIDTH];
  end

  assign in_show = (state == SHOW);
  assign advance = next_pulse | (auto_en & dwell_tc);

  // Dwell only accumulates while showing data with auto mode on; any advance restarts it.
  led_dwell_timer #(
    .CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (advance | ~auto_en | ~in_show),
    .enable(auto_en & in_show),
    .tc    (dwell_tc)
  );

`ifdef LED_SCAN_INDEX_FLASH_EN
  scan_state_e      state_q, state_d;
  logic             flash_tc;
  logic [WIDTH-1:0] flash_pat;

  led_dwell_timer #(
    .CYCLES(FLASH_CYCLES)
  ) u_flash (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (advance | in_show),
    .enable(~in_show),
    .tc    (flash_tc)
  );

  // One-hot index when every channel has its own LED, otherwise the binary index.
  if (WIDTH >= CHANNELS) begin : g_onehot
    assign flash_pat = WIDTH'(1) << sel_q;
  end else begin : g_binary
    assign flash_pat = WIDTH'(sel_q);
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = FLASH;
    end else if ((state_q == FLASH) && flash_tc) begin
      state_d = SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHOW;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
`else
  assign state = SHOW;
`endif

  always_comb begin
    sel_d = sel_q;
    if (advance) begin
      sel_d = (sel_q == SELW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  always_comb begin
    leds_d = ch_word[sel_q];
`ifdef LED_SCAN_INDEX_FLASH_EN
    if (!in_show) begin
      leds_d = flash_pat;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      leds_q <= '0;
    end else begin
      sel_q  <= sel_d;
      leds_q <= leds_d;
    end
  end

  assign sel  = sel_q;
  assign leds = leds_q;

endmodule
